rf_wb_arbiter: RTL and testbench

Write-side controller for the CPU register file: it owns the single RF write port (RFWr/A3/WD) and merges the in-order pipeline writeback stream with results returning from long-latency units (multiply/divide, load misses). Long-latency results are buffered in a small FIFO. A per-register scoreboard flags registers with a result still outstanding, so decode can stall on RAW hazards. It sits between the WB stage and the RF, and the scoreboard query is made from decode.

---
 rtl/rf_wb_arbiter_pkg.sv | 23 ++
 rtl/rf_wb_fifo.sv | 63 ++++++
 rtl/rf_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU constants and types for the register-file write-side controller.
//   REG_AW / DATA_W : register address and data widths
//   REG_ZERO        : hard-wired zero register, never written or marked busy
//   wb_ent_t        : one buffered long-latency result {rd, wd}
//   wb_src_e        : which source owns the RF write port this cycle
package rf_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] wd;
  } wb_ent_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO for long-latency results {rd, wd}.
//   clk, rst        : clock, async active-low reset (empties the FIFO)
//   push_i, rd_i, wd_i : write side; ignored while full
//   pop_i           : read side; ignored while empty
//   rd_o, wd_o      : head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy status
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [REG_AW-1:0]      rd_i,
  input  logic [DATA_W-1:0]      wd_i,
  input  logic                   pop_i,
  output logic [REG_AW-1:0]      rd_o,
  output logic [DATA_W-1:0]      wd_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_ent_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q;
  logic           do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rd_o    = mem_q[rd_ptr_q].rd;
  assign wd_o    = mem_q[rd_ptr_q].wd;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= '{rd: rd_i, wd: wd_i};
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the single RF write port. Merges the in-order WB stream with buffered
// long-latency results and keeps a per-register busy scoreboard for decode.
//   clk, rst                    : clock, async active-low reset
//   pipe_we/rd/wd, pipe_stall   : WB stage request; stall holds it one cycle
//   iss_valid, iss_rd           : long-latency issue, marks rd busy
//   llu_valid/rd/wd, llu_ready  : long-latency result into the FIFO
//   rs, rt, rs_busy, rt_busy    : combinational scoreboard query
//   rf_we, rf_a3, rf_wd         : registered RF write port
//   fifo_count                  : FIFO occupancy
// STARVE_MAX must be >= 2.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [REG_AW-1:0]      pipe_rd,
  input  logic [DATA_W-1:0]      pipe_wd,
  output logic                   pipe_stall,
  input  logic                   iss_valid,
  input  logic [REG_AW-1:0]      iss_rd,
  input  logic                   llu_valid,
  output logic                   llu_ready,
  input  logic [REG_AW-1:0]      llu_rd,
  input  logic [DATA_W-1:0]      llu_wd,
  input  logic [REG_AW-1:0]      rs,
  input  logic [REG_AW-1:0]      rt,
  output logic                   rs_busy,
  output logic                   rt_busy,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_a3,
  output logic [DATA_W-1:0]      rf_wd,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(STARVE_MAX - 1);

  logic              fifo_full, fifo_empty;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_wd;
  logic              push, pop;
  wb_src_e           src;

  logic [REG_AW-1:0] win_rd;
  logic [DATA_W-1:0] win_wd;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_a3_q;
  logic [DATA_W-1:0] rf_wd_q;
  logic              src_fifo_q;
  logic              pipe_stall_q, pipe_stall_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [31:0]       busy_q, busy_d;

  assign llu_ready = !fifo_full;
  assign push      = llu_valid && llu_ready;
  assign pop       = (src == SRC_FIFO);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .rd_i    (llu_rd),
    .wd_i    (llu_wd),
    .pop_i   (pop),
    .rd_o    (head_rd),
    .wd_o    (head_wd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    src    = SRC_NONE;
    win_rd = REG_ZERO;
    win_wd = '0;
    if (!pipe_stall_q && pipe_we) begin
      src    = SRC_PIPE;
      win_rd = pipe_rd;
      win_wd = pipe_wd;
    end else if (!fifo_empty) begin
      src    = SRC_FIFO;
      win_rd = head_rd;
      win_wd = head_wd;
    end
  end

  // A winner targeting r0 is consumed but never reaches the RF.
  assign rf_we_d = (src != SRC_NONE) && (win_rd != REG_ZERO);

  // Counter only grows while a queued head loses; the stall is raised one
  // cycle ahead so the head drains on the STARVE_MAX-th waiting cycle.
  always_comb begin
    starve_d     = '0;
    pipe_stall_d = 1'b0;
    if (src == SRC_PIPE && !fifo_empty) begin
      starve_d     = starve_q + 1'b1;
      pipe_stall_d = (starve_d == STALL_AT);
    end
  end

  // Clear on a FIFO commit, then set on issue so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q && src_fifo_q) busy_d[rf_a3_q] = 1'b0;
    if (iss_valid && iss_rd != REG_ZERO) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      src_fifo_q   <= 1'b0;
      pipe_stall_q <= 1'b0;
      starve_q     <= '0;
      busy_q       <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      src_fifo_q   <= (src == SRC_FIFO);
      pipe_stall_q <= pipe_stall_d;
      starve_q     <= starve_d;
      busy_q       <= busy_d;
      if (src != SRC_NONE) begin
        rf_a3_q <= win_rd;
        rf_wd_q <= win_wd;
      end
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_a3      = rf_a3_q;
  assign rf_wd      = rf_wd_q;
  assign pipe_stall = pipe_stall_q;
  assign rs_busy    = (rs != REG_ZERO) && busy_q[rs];
  assign rt_busy    = (rt != REG_ZERO) && busy_q[rt];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_wd = '0;
  logic        pipe_stall;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        llu_valid = 1'b0;
  logic        llu_ready;
  logic [4:0]  llu_rd = '0;
  logic [31:0] llu_wd = '0;
  logic [4:0]  rs = '0, rt = '0;
  logic        rs_busy, rt_busy;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_rd(llu_rd), .llu_wd(llu_wd),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of pending results, a busy array and a count
  // of cycles the oldest pending result has been passed over.
  typedef struct packed { logic [4:0] rd; logic [31:0] wd; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_busy;
  int          m_wait;
  bit          m_stall, m_we, m_from_q;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  function automatic void m_reset();
    mq.delete();
    m_busy = '0; m_wait = 0; m_stall = 0; m_we = 0; m_from_q = 0;
    m_a3 = '0; m_wd = '0;
  endfunction

  task automatic step();
    bit          pw, fq, room, s_we, s_llu, s_iss;
    logic [4:0]  s_prd, s_lrd, s_ird;
    logic [31:0] s_pwd, s_lwd, nb;
    int          n, nw;
    ent_t        e;
    n = mq.size();
    s_we = pipe_we; s_prd = pipe_rd; s_pwd = pipe_wd;
    s_llu = llu_valid; s_lrd = llu_rd; s_lwd = llu_wd;
    s_iss = iss_valid; s_ird = iss_rd;
    pw   = !m_stall && s_we;
    fq   = !pw && n > 0;
    room = n < DEPTH;
    nb = m_busy;
    if (m_we && m_from_q) nb[m_a3] = 1'b0;
    if (s_iss && s_ird != 0) nb[s_ird] = 1'b1;
    nw = (pw && n > 0) ? m_wait + 1 : 0;
    @(posedge clk);
    m_busy  = nb;
    m_wait  = nw;
    m_stall = (nw == STARVE_MAX - 1);
    if (pw) begin
      m_we = (s_prd != 0); m_a3 = s_prd; m_wd = s_pwd; m_from_q = 0;
    end else if (fq) begin
      e = mq.pop_front();
      m_we = (e.rd != 0); m_a3 = e.rd; m_wd = e.wd; m_from_q = 1;
    end else begin
      m_we = 0; m_from_q = 0;
    end
    if (s_llu && room) mq.push_back('{rd: s_lrd, wd: s_lwd});
    #1;
    chk("m_rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("m_rf_a3", 32'(rf_a3), 32'(m_a3));
      chk("m_rf_wd", rf_wd, m_wd);
    end
    chk("m_pipe_stall", 32'(pipe_stall), 32'(m_stall));
    chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("m_llu_ready", 32'(llu_ready), 32'(mq.size() < DEPTH));
    chk("m_rs_busy", 32'(rs_busy), 32'(rs != 0 && m_busy[rs]));
    chk("m_rt_busy", 32'(rt_busy), 32'(rt != 0 && m_busy[rt]));
  endtask

  task automatic idle();
    pipe_we = 0; llu_valid = 0; iss_valid = 0;
  endtask

  task automatic chk_busy_clear(string nm);
    logic any;
    any = 1'b0;
    for (int r = 0; r < 32; r++) begin
      rs = 5'(r); rt = 5'(r); #1;
      any = any | rs_busy | rt_busy;
    end
    chk(nm, 32'(any), 32'd0);
  endtask

  typedef struct {
    logic pwe; logic [4:0] prd; logic [31:0] pwd;
    logic lv;  logic [4:0] lrd; logic [31:0] lwd;
    logic iv;  logic [4:0] ird;
    logic [4:0] qs, qt;
    logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic e_rsb, e_rtb; int e_cnt;
  } vec_t;

  function automatic vec_t mk(logic pwe, logic [4:0] prd, logic [31:0] pwd,
                              logic lv, logic [4:0] lrd, logic [31:0] lwd,
                              logic iv, logic [4:0] ird, logic [4:0] qs, logic [4:0] qt,
                              logic e_we, logic [4:0] e_a3, logic [31:0] e_wd,
                              logic e_rsb, logic e_rtb, int e_cnt);
    vec_t v;
    v.pwe = pwe; v.prd = prd; v.pwd = pwd; v.lv = lv; v.lrd = lrd; v.lwd = lwd;
    v.iv = iv; v.ird = ird; v.qs = qs; v.qt = qt;
    v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd;
    v.e_rsb = e_rsb; v.e_rtb = e_rtb; v.e_cnt = e_cnt;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t tv[NV];

  initial begin
    int         stalls, stall_at;
    logic [4:0] got[$];

    //            pipe           llu                  iss    rs rt  we a3 wd              rsb rtb cnt
    tv[0]  = mk(1, 3, 32'h1234, 0, 0, 0,             0, 0,  3, 0, 1, 3, 32'h00001234,     0, 0, 0);
    tv[1]  = mk(0, 0, 0,        0, 0, 0,             1, 5,  5, 0, 0, 0, 0,                1, 0, 0);
    tv[2]  = mk(0, 0, 0,        1, 5, 32'hDEADBEEF,  0, 0,  5, 0, 0, 0, 0,                1, 0, 1);
    tv[3]  = mk(0, 0, 0,        0, 0, 0,             0, 0,  5, 0, 1, 5, 32'hDEADBEEF,     1, 0, 0);
    tv[4]  = mk(0, 0, 0,        0, 0, 0,             0, 0,  5, 0, 0, 0, 0,                0, 0, 0);
    tv[5]  = mk(1, 0, 32'h55,   1, 0, 32'h66,        0, 0,  0, 0, 0, 0, 0,                0, 0, 1);
    tv[6]  = mk(0, 0, 0,        0, 0, 0,             0, 0,  0, 0, 0, 0, 0,                0, 0, 0);
    tv[7]  = mk(0, 0, 0,        0, 0, 0,             1, 7,  7, 0, 0, 0, 0,                1, 0, 0);
    tv[8]  = mk(0, 0, 0,        1, 7, 32'h77,        0, 0,  7, 0, 0, 0, 0,                1, 0, 1);
    tv[9]  = mk(0, 0, 0,        0, 0, 0,             0, 0,  7, 0, 1, 7, 32'h77,           1, 0, 0);
    tv[10] = mk(0, 0, 0,        0, 0, 0,             1, 7,  7, 0, 0, 0, 0,                1, 0, 0);
    tv[11] = mk(0, 0, 0,        0, 0, 0,             0, 0,  7, 0, 0, 0, 0,                1, 0, 0);
    tv[12] = mk(0, 0, 0,        1, 9, 32'h99,        0, 0,  9, 7, 0, 0, 0,                0, 1, 1);
    tv[13] = mk(0, 0, 0,        0, 0, 0,             0, 0,  9, 7, 1, 9, 32'h99,           0, 1, 0);
    tv[14] = mk(0, 0, 0,        0, 0, 0,             0, 0,  9, 7, 0, 0, 0,                0, 1, 0);

    // Reset state
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_a3", 32'(rf_a3), 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_pipe_stall", 32'(pipe_stall), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_llu_ready", 32'(llu_ready), 1);
    chk_busy_clear("rst_busy");
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      pipe_we = tv[i].pwe; pipe_rd = tv[i].prd; pipe_wd = tv[i].pwd;
      llu_valid = tv[i].lv; llu_rd = tv[i].lrd; llu_wd = tv[i].lwd;
      iss_valid = tv[i].iv; iss_rd = tv[i].ird;
      rs = tv[i].qs; rt = tv[i].qt;
      step();
      chk($sformatf("tv%0d_rf_we", i), 32'(rf_we), 32'(tv[i].e_we));
      if (tv[i].e_we) begin
        chk($sformatf("tv%0d_rf_a3", i), 32'(rf_a3), 32'(tv[i].e_a3));
        chk($sformatf("tv%0d_rf_wd", i), rf_wd, tv[i].e_wd);
      end
      chk($sformatf("tv%0d_rs_busy", i), 32'(rs_busy), 32'(tv[i].e_rsb));
      chk($sformatf("tv%0d_rt_busy", i), 32'(rt_busy), 32'(tv[i].e_rtb));
      chk($sformatf("tv%0d_count", i), 32'(fifo_count), 32'(tv[i].e_cnt));
    end
    idle();

    // Starvation: pipeline writes every cycle while four results queue up
    stalls = 0; stall_at = -1;
    rs = 0; rt = 0;
    for (int c = 0; c < 12; c++) begin
      pipe_we = 1; pipe_rd = 5'(1 + c % 8); pipe_wd = 32'(c);
      llu_valid = (c < 6); llu_rd = 5'(10 + c); llu_wd = 32'hA0 + 32'(c);
      step();
      if (c == 3) begin
        chk("starve_full_ready", 32'(llu_ready), 0);
        chk("starve_full_count", 32'(fifo_count), 4);
      end
      if (c == STARVE_MAX) begin
        chk("starve_drain_we", 32'(rf_we), 1);
        chk("starve_drain_a3", 32'(rf_a3), 10);
        chk("starve_drain_wd", rf_wd, 32'hA0);
        chk("starve_drain_count", 32'(fifo_count), 3);
      end
      if (pipe_stall) begin
        stalls++;
        if (stall_at < 0) stall_at = c;
      end
    end
    chk("starve_pulses", 32'(stalls), 1);
    chk("starve_lost_cycles", 32'(stall_at), 32'(STARVE_MAX - 1));
    idle();
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      step();
      if (rf_we) got.push_back(rf_a3);
    end
    chk("order_n", 32'(got.size()), 3);
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk($sformatf("order_%0d", k), 32'(got[k]), 32'(11 + k));

    // Reset mid-operation
    iss_valid = 1; iss_rd = 20; step();
    iss_rd = 21; step();
    iss_valid = 0;
    for (int c = 0; c < 4; c++) begin
      pipe_we = 1; pipe_rd = 5'(4 + c); pipe_wd = 32'h100 + 32'(c);
      llu_valid = (c < 3); llu_rd = 5'(20 + c); llu_wd = 32'h200 + 32'(c);
      step();
    end
    chk("pre_rst_we", 32'(rf_we), 1);
    chk("pre_rst_count", 32'(fifo_count), 3);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rf_we", 32'(rf_we), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_ready", 32'(llu_ready), 1);
    chk("mid_rst_stall", 32'(pipe_stall), 0);
    chk_busy_clear("mid_rst_busy");
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      pipe_we   = ($urandom_range(0, 9) < 6);
      pipe_rd   = 5'($urandom_range(0, 31));
      pipe_wd   = $urandom;
      llu_valid = ($urandom_range(0, 1) == 1);
      llu_rd    = 5'($urandom_range(0, 31));
      llu_wd    = $urandom;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_rd    = 5'($urandom_range(0, 31));
      rs        = 5'($urandom_range(0, 31));
      rt        = 5'($urandom_range(0, 31));
      step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
